// File: rtl/alu_pkg.sv
// Shared constants and helpers for the ALU operand-select arbiter.
// Covers the state encoding, the requester count and a one-hot helper.
package alu_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Circular priority search over the request mask.
// The search starts at i_ptr and reports the first set bit.
module rr_priority_pick
  import alu_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  always_comb begin
    logic [IDX_W-1:0] w_cand;
    w_cand  = i_ptr;
    o_found = 1'b0;
    o_idx   = i_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      // The index sum wraps naturally at IDX_W bits, giving the mod-4 walk.
      w_cand = i_ptr + IDX_W'(i);
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/alu_operand_arbiter.sv
// Round-robin owner arbiter for the shared 4:1 operand mux and its ALU.
// All outputs come straight from registers; busy mirrors the FSM state.
module alu_operand_arbiter
  import alu_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               S1,
  output logic               S0,
  output logic               busy,
  output logic [CNT_W-1:0]   owner_cycles
);

  logic               r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_sel;
  logic [NUM_REQ-1:0] r_gnt;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_state;
  logic [IDX_W-1:0]   w_ptr;
  logic [IDX_W-1:0]   w_sel;
  logic [NUM_REQ-1:0] w_gnt;
  logic [CNT_W-1:0]   w_cnt;

  logic [NUM_REQ-1:0] w_owner_mask;
  logic [NUM_REQ-1:0] w_excl_req;
  logic [IDX_W-1:0]   w_ptr_after;
  logic               w_idle_found;
  logic [IDX_W-1:0]   w_idle_idx;
  logic               w_next_found;
  logic [IDX_W-1:0]   w_next_idx;
  logic               w_keep;

  // The handover pick excludes the owner, so release and expiry share it.
  assign w_owner_mask = idx_to_onehot(r_sel);
  assign w_excl_req   = req & ~w_owner_mask;
  assign w_ptr_after  = r_sel + IDX_W'(1);
  assign w_keep       = req[r_sel] && (r_cnt < CNT_W'(MAX_HOLD));

  rr_priority_pick u_pick_idle (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_found (w_idle_found),
    .o_idx   (w_idle_idx)
  );

  rr_priority_pick u_pick_next (
    .i_req   (w_excl_req),
    .i_ptr   (w_ptr_after),
    .o_found (w_next_found),
    .o_idx   (w_next_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_gnt   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_sel   <= w_sel;
      r_gnt   <= w_gnt;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_sel   = r_sel;
    w_gnt   = r_gnt;
    w_cnt   = r_cnt;
    if (r_state == ST_IDLE) begin
      if (w_idle_found) begin
        w_state = ST_GRANT;
        w_sel   = w_idle_idx;
        w_gnt   = idx_to_onehot(w_idle_idx);
        w_cnt   = CNT_W'(1);
      end else begin
        w_gnt = '0;
        w_cnt = '0;
      end
    end else if (w_keep) begin
      w_cnt = r_cnt + CNT_W'(1);
    end else begin
      // Release or expiry: advance past the owner and hand over without a bubble.
      w_ptr = w_ptr_after;
      w_cnt = CNT_W'(1);
      if (w_next_found) begin
        w_sel = w_next_idx;
        w_gnt = idx_to_onehot(w_next_idx);
      end else if (!req[r_sel]) begin
        w_state = ST_IDLE;
        w_gnt   = '0;
        w_cnt   = '0;
      end
    end
  end

  always_comb begin
    gnt          = r_gnt;
    S1           = r_sel[1];
    S0           = r_sel[0];
    busy         = (r_state == ST_GRANT);
    owner_cycles = r_cnt;
  end

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// Bench for alu_operand_arbiter: directed scenarios with literal expectations,
// then random requests checked every cycle against a behavioural model.
module tb_alu_operand_arbiter;

  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic             S1;
  logic             S0;
  logic             busy;
  logic [CNT_W-1:0] owner_cycles;

  int n_checks;
  int n_fail;

  logic [10:0] exp_q[$];

  alu_operand_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .gnt          (gnt),
    .S1           (S1),
    .S0           (S0),
    .busy         (busy),
    .owner_cycles (owner_cycles)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: owner is -1 when nobody holds the datapath.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_cnt   = 0;

  function automatic int pick(input logic [3:0] r, input int start, input int excl);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (start + k) % 4;
      if (c != excl && r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    logic [3:0] eg;
    logic [1:0] es;
    logic [3:0] ec;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_sel = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      w = pick(req, m_ptr, -1);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_cnt = 1;
      end else begin
        m_cnt = 0;
      end
    end else if (req[m_owner] && m_cnt < MAX_HOLD) begin
      m_cnt = m_cnt + 1;
    end else begin
      m_ptr = (m_owner + 1) % 4;
      w = pick(req, m_ptr, m_owner);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_cnt = 1;
      end else if (req[m_owner]) begin
        m_cnt = 1;
      end else begin
        m_owner = -1; m_cnt = 0;
      end
    end
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    es = 2'(m_sel);
    ec = 4'(m_cnt);
    exp_q.push_back({eg, es, (m_owner >= 0), ec});
  end

  // Scoreboard: one compare per cycle plus structural invariants.
  always @(negedge clk) begin
    logic [10:0] e;
    logic [10:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {gnt, S1, S0, busy, owner_cycles};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL model t=%0t: gnt/sel/busy/cnt got %b/%b/%b/%0d required %b/%b/%b/%0d",
                 $time, a[10:7], a[6:5], a[4], a[3:0], e[10:7], e[6:5], e[4], e[3:0]);
      end
      n_checks++;
      if ($countones(gnt) > 1 || busy !== (|gnt)) begin
        n_fail++;
        $display("FAIL invariant t=%0t: gnt=%b busy=%b required one-hot/zero and busy==|gnt",
                 $time, gnt, busy);
      end
    end
  end

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic reset_pulse(input logic [3:0] r);
    rst = 1'b1;
    req = r;
    cyc(1);
    rst = 1'b0;
  endtask

  logic [3:0] rot_gnt[4];
  logic [1:0] rot_sel[4];

  initial begin
    int max_cnt;
    int bad;
    logic [3:0] g[32];
    n_checks = 0;
    n_fail   = 0;
    rot_gnt  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_sel  = '{2'b01, 2'b10, 2'b11, 2'b00};

    // Reset then idle
    rst = 1'b1;
    req = 4'b1111;
    cyc(2);
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_cnt", 32'(owner_cycles), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    cyc(1);
    check("first_gnt", 32'(gnt), 32'b0001);
    check("first_sel", 32'({S1, S0}), 32'b00);

    // Round-robin rotation with one-cycle drops
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      req = 4'b1111 & ~(4'b0001 << ((k) % 4));
      cyc(1);
      check("rot_gnt", 32'(gnt), 32'(rot_gnt[k]));
      check("rot_sel", 32'({S1, S0}), 32'(rot_sel[k]));
      check("rot_busy", 32'(busy), 32'h1);
      req = 4'b1111;
    end

    // Hold expiry between two requesters
    reset_pulse(4'b0101);
    max_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1);
      g[i] = gnt;
      if (int'(owner_cycles) > max_cnt) max_cnt = int'(owner_cycles);
    end
    check("hold_first", 32'(g[0]), 32'b0001);
    check("hold_last0", 32'(g[7]), 32'b0001);
    check("hold_switch", 32'(g[8]), 32'b0100);
    check("hold_last2", 32'(g[15]), 32'b0100);
    check("hold_back", 32'(g[16]), 32'b0001);
    check("hold_peak", 32'(max_cnt), 32'd8);

    // Lone requester re-granted at expiry
    reset_pulse(4'b0010);
    bad = 0;
    max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (gnt !== 4'b0010 || busy !== 1'b1) bad++;
      if (int'(owner_cycles) > max_cnt) max_cnt = int'(owner_cycles);
      if (i == 7) check("lone_peak_cnt", 32'(owner_cycles), 32'd8);
      if (i == 8) check("lone_restart_cnt", 32'(owner_cycles), 32'd1);
    end
    check("lone_steady", 32'(bad), 32'd0);
    check("lone_max", 32'(max_cnt), 32'd8);

    // Release to idle
    reset_pulse(4'b1000);
    cyc(3);
    check("rel_gnt", 32'(gnt), 32'b1000);
    check("rel_cnt", 32'(owner_cycles), 32'd3);
    req = 4'b0000;
    cyc(1);
    check("rel_idle_gnt", 32'(gnt), 32'h0);
    check("rel_idle_busy", 32'(busy), 32'h0);
    check("rel_idle_sel", 32'({S1, S0}), 32'b11);
    cyc(2);
    check("rel_idle_hold_sel", 32'({S1, S0}), 32'b11);

    // Reset mid-grant
    reset_pulse(4'b0100);
    cyc(5);
    check("mid_gnt", 32'(gnt), 32'b0100);
    check("mid_cnt", 32'(owner_cycles), 32'd5);
    rst = 1'b1;
    req = 4'b0101;
    cyc(1);
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_cnt", 32'(owner_cycles), 32'h0);
    rst = 1'b0;
    cyc(1);
    check("mid_after_gnt", 32'(gnt), 32'b0001);

    // Random traffic: fast-changing, then slow-changing requests
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) req = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    rst = 1'b0;
    req = 4'b0000;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_arbiter.md
Name: alu_operand_arbiter

Overview:
- Round-robin arbiter that shares the single 4:1 operand-select mux and its downstream 4-bit ALU among four requesters.
- Each cycle it decides which requester owns the datapath. It drives the mux selects S1/S0 with the owner's index and asserts a one-hot grant.
- A requester holds ownership while its request stays high, up to a bounded hold limit. This prevents starvation.
- Sits between the requester logic and the mux select inputs.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one requester keeps the grant while others are waiting. Legal range 1..15.
- CNT_W, 4: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  request vector; bit i = requester i (drives mux input Ii)
- gnt  output 4  one-hot grant, registered; all zero when idle
- S1   output 1  mux select MSB = owner index bit 1, registered
- S0   output 1  mux select LSB = owner index bit 0, registered
- busy output 1  high while in GRANT state, registered
- owner_cycles output CNT_W  cycles the current owner has held the grant (debug/perf), registered

Behaviour:
- Reset (rst high at a clock edge):
  - Next state: gnt=0000, S1=0, S0=0, busy=0, owner_cycles=0, state IDLE.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
  - rst has priority over all other events. Asserting it mid-grant drops the grant on that same edge.
- States: IDLE, GRANT.
- Winner selection: first requester with req high, searching circularly from the pointer (pointer, pointer+1, ... mod 4).
- IDLE:
  - req==0000: stay in IDLE. gnt=0, S1/S0 hold their last value.
  - Any req bit high: on the next edge, grant the winner. gnt=onehot(winner), {S1,S0}=winner, busy=1, owner_cycles=1, go to GRANT.
  - Latency from req to gnt is 1 cycle.
- GRANT (owner o):
  - Keep (req[o]=1 and owner_cycles<MAX_HOLD): grant unchanged, owner_cycles increments.
  - Release (req[o]=0): pointer=(o+1) mod 4.
    - Other requests pending: grant the winner from the new pointer on the same edge. No idle bubble; owner_cycles=1.
    - No requests pending: go to IDLE with gnt=0 and busy=0.
  - Expire (req[o]=1 and owner_cycles==MAX_HOLD): pointer=(o+1) mod 4.
    - Any other req bit high: switch to the winner among the others; owner_cycles=1.
    - No other request: re-grant o and restart owner_cycles at 1.
  - owner_cycles never exceeds MAX_HOLD and never wraps.
- Invariants:
  - gnt is one-hot or zero.
  - When gnt!=0, {S1,S0} equals the index of the set gnt bit.
  - busy==|gnt.
- A requester dropping req and re-raising it on the following cycle is treated as a new request. It waits its round-robin turn.
- All outputs are registered. There is no combinational path from req to outputs.

Decomposition:
- Shared package alu_pkg:
  - State encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Requester count constant NUM_REQ=4.
  - Index width constant IDX_W=2.
- One natural sub-module: rr_priority_pick. Purely combinational.
  - Inputs: 4-bit request mask and 2-bit pointer.
  - Outputs: found flag and 2-bit winner index.
  - Reused for both the normal pick and the pick that excludes the owner.

Test Plan:
- Reset then idle: rst for 2 cycles with req=1111, then release rst → gnt=0000 during reset; gnt=0001, S1S0=00 one cycle after rst falls.
- Round-robin rotation: req=1111 with each owner dropping req for one cycle after 2 cycles → grants go 0001→0010→0100→1000→0001 with no idle cycles, and S1S0 tracks 00,01,10,11.
- Hold expiry: MAX_HOLD=8, req=0101 held constant → gnt=0001 for exactly 8 cycles, then 0100 for 8, alternating; owner_cycles peaks at 8.
- Lone requester: req=0010 held for 20 cycles → gnt=0010 continuously, owner_cycles cycles 1..8 and restarts, busy never drops.
- Release to idle: req=1000 for 3 cycles then 0000 → gnt=1000 for 3 cycles, then gnt=0000 and busy=0; S1S0 stays 11.
- Reset mid-grant: rst pulsed while gnt=0100 and owner_cycles=5 → next cycle gnt=0000 and owner_cycles=0. With req=0101 after reset, requester 0 wins (pointer back to 0).
